// File: rtl/reset_requester_pkg.sv
// Shared type codes, FSM encoding and pending-slot merge helper for the reset requester.
package reset_requester_pkg;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'b00,
        REQ_SOFT   = 2'b01,
        REQ_HARD   = 2'b10,
        REQ_PERIPH = 2'b11
    } req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ASSERT   = 2'b01,
        ST_RELEASE  = 2'b10,
        ST_COOLDOWN = 2'b11
    } state_e;

    // One-slot merge for button events: hard overwrites anything, soft only fills an empty slot.
    function automatic req_type_e merge_btn(input req_type_e held, input req_type_e evt);
        if (evt == REQ_HARD) begin
            return REQ_HARD;
        end
        if ((evt == REQ_SOFT) && (held == REQ_NONE)) begin
            return REQ_SOFT;
        end
        return held;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Front-panel button synchroniser, debouncer and short/long press classifier.
// Emits one-cycle soft_evt_o on a short press release and hard_evt_o once a hold
// reaches LONG_PRESS_CYCLES; a long press produces no event on its release.
module btn_debounce
    import reset_requester_pkg::*;
#(
    parameter int SYNC_STAGES       = 3,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic soft_evt_o,
    output logic hard_evt_o
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic                   deb_q, deb_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   fired_q, fired_d;
    logic                   soft_q, soft_d;
    logic                   hard_q, hard_d;

    assign btn_s      = sync_q[SYNC_STAGES-1];
    assign soft_evt_o = soft_q;
    assign hard_evt_o = hard_q;

    // Debounce counts consecutive disagreeing cycles; hold counter measures the debounced press.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (btn_s != deb_q) begin
            if (deb_cnt_q >= DEB_LAST) begin
                deb_d = btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        hold_d  = '0;
        fired_d = 1'b0;
        hard_d  = 1'b0;
        if (deb_q) begin
            hold_d  = (hold_q >= HOLD_MAX) ? hold_q : hold_q + 1'b1;
            fired_d = fired_q;
            if ((hold_q == HOLD_LAST) && !fired_q) begin
                hard_d  = 1'b1;
                fired_d = 1'b1;
            end
        end
        // A release only counts as a soft press if the hold never escalated.
        soft_d = deb_q && !deb_d && !fired_q && !hard_d;
    end

    // Synchroniser chain plus debounce/press state, all cleared by the async reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            hold_q    <= '0;
            fired_q   <= 1'b0;
            soft_q    <= 1'b0;
            hard_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            hold_q    <= hold_d;
            fired_q   <= fired_d;
            soft_q    <= soft_d;
            hard_q    <= hard_d;
        end
    end

endmodule

// File: rtl/reset_requester.sv
// Reset request arbiter: merges button and CPU reset requests, drives one request
// level at a time and handshakes with the reset generator's acknowledge lines.
module reset_requester
    import reset_requester_pkg::*;
#(
    parameter int SYNC_STAGES       = 3,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1024,
    parameter int ACK_TIMEOUT       = 255,
    parameter int COOLDOWN_CYCLES   = 32
) (
    input  logic       clk_peripheral,
    input  logic       aresetn,
    input  logic       btn_reset,
    input  logic       cpu_req_valid,
    input  logic [1:0] cpu_req_type,
    output logic       cpu_req_ready,
    input  logic       mb_reset,
    input  logic       peripheral_reset,
    output logic       reset_hard,
    output logic       reset_soft,
    output logic       reset_peripheral,
    output logic       busy,
    output logic [1:0] last_type,
    output logic       timeout_err,
    input  logic       err_clear
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_CYCLES - 1);

    logic [SYNC_STAGES-1:0] mb_sync_q, pr_sync_q;
    logic                   mb_s, pr_s;
    logic                   btn_soft, btn_hard;

    state_e           state_q, state_d;
    req_type_e        cur_q, cur_d;
    req_type_e        last_q, last_d;
    req_type_e        pend_q, pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             err_q, err_d;

    req_type_e btn_evt, btn_req, cpu_type, sel;
    logic      sel_btn, need_mb, need_pr, ack_all, ack_none, tmo_hit;

    btn_debounce #(
        .SYNC_STAGES      (SYNC_STAGES),
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_btn (
        .clk_i     (clk_peripheral),
        .rst_ni    (aresetn),
        .btn_i     (btn_reset),
        .soft_evt_o(btn_soft),
        .hard_evt_o(btn_hard)
    );

    // Acknowledge synchronisers; only the last stage is used by the FSM.
    always_ff @(posedge clk_peripheral or negedge aresetn) begin
        if (!aresetn) begin
            mb_sync_q <= '0;
            pr_sync_q <= '0;
        end else begin
            mb_sync_q <= {mb_sync_q[SYNC_STAGES-2:0], mb_reset};
            pr_sync_q <= {pr_sync_q[SYNC_STAGES-2:0], peripheral_reset};
        end
    end

    assign mb_s = mb_sync_q[SYNC_STAGES-1];
    assign pr_s = pr_sync_q[SYNC_STAGES-1];

    // Arbitration: hard from either source, then button soft, then CPU soft/peripheral.
    always_comb begin
        btn_evt  = btn_hard ? REQ_HARD : (btn_soft ? REQ_SOFT : REQ_NONE);
        btn_req  = merge_btn(pend_q, btn_evt);
        cpu_type = req_type_e'(cpu_req_type);
        sel      = REQ_NONE;
        sel_btn  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (btn_req == REQ_HARD) begin
                sel     = REQ_HARD;
                sel_btn = 1'b1;
            end else if (cpu_req_valid && (cpu_type == REQ_HARD)) begin
                sel = REQ_HARD;
            end else if (btn_req == REQ_SOFT) begin
                sel     = REQ_SOFT;
                sel_btn = 1'b1;
            end else if (cpu_req_valid && (cpu_type != REQ_NONE)) begin
                sel = cpu_type;
            end
        end
        // The CPU is stalled whenever the button owns this IDLE cycle.
        cpu_req_ready = (state_q == ST_IDLE) && !sel_btn;

        need_mb  = (cur_q == REQ_SOFT) || (cur_q == REQ_HARD);
        need_pr  = (cur_q == REQ_PERIPH) || (cur_q == REQ_HARD);
        ack_all  = (!need_mb || mb_s) && (!need_pr || pr_s);
        ack_none = !(need_mb && mb_s) && !(need_pr && pr_s);
    end

    // FSM next state, counters, pending slot and sticky timeout flag.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        pend_d  = btn_req;
        tmo_d   = tmo_q;
        cd_d    = cd_q;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_btn) begin
                    pend_d = REQ_NONE;
                end
                if (sel != REQ_NONE) begin
                    state_d = ST_ASSERT;
                    cur_d   = sel;
                    last_d  = sel;
                    tmo_d   = '0;
                end
            end
            ST_ASSERT: begin
                if (ack_all) begin
                    state_d = ST_RELEASE;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = ST_COOLDOWN;
                    cd_d    = '0;
                    tmo_hit = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (ack_none) begin
                    state_d = ST_COOLDOWN;
                    cd_d    = '0;
                end
            end
            ST_COOLDOWN: begin
                if (cd_q >= CD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cd_d = cd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new timeout wins over a simultaneous clear.
        err_d = tmo_hit ? 1'b1 : (err_clear ? 1'b0 : err_q);
    end

    // State register for the FSM and its bookkeeping.
    always_ff @(posedge clk_peripheral or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cur_q   <= REQ_NONE;
            last_q  <= REQ_NONE;
            pend_q  <= REQ_NONE;
            tmo_q   <= '0;
            cd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            cd_q    <= cd_d;
            err_q   <= err_d;
        end
    end

    assign reset_hard       = (state_q == ST_ASSERT) && (cur_q == REQ_HARD);
    assign reset_soft       = (state_q == ST_ASSERT) && (cur_q == REQ_SOFT);
    assign reset_peripheral = (state_q == ST_ASSERT) && (cur_q == REQ_PERIPH);
    assign busy             = (state_q != ST_IDLE);
    assign last_type        = last_q;
    assign timeout_err      = err_q;

endmodule
